// File: rtl/sn74xx151.sv
// ---------------------------------------------------------------------------
// sn74xx151 -- 8-to-1 data selector/multiplexer modelled on the 74x151.
//
// The strobe is active-low, and the selector drives complementary outputs.
// A clocked register stage provides synchronous copies of the result for
// downstream clocked logic in the sn74 library.
//
// Parameters:
//   RESET_Q  value loaded into q on reset; _q resets to ~RESET_Q.
//
// Ports:
//   clk   in   1  rising-edge clock for the register stage(s)
//   rst   in   1  asynchronous, active-high reset (register stages only)
//   a     in   8  data inputs D0..D7, a[0] = D0
//   sel   in   3  select code, sel=n routes a[n]
//   str   in   1  strobe, active-low; 1 forces out=0 / _out=1
//   out   out  1  Y, selected data
//   _out  out  1  W, complement of out
//   q     out  1  Y captured on clk
//   _q    out  1  W captured on clk
//
// Optional build macro:
//   SN74XX151_INPUT_REG_EN  registers a/sel/str before the selector.
//     out/_out then lag the ports by one cycle and q/_q lag by two.
//     Under reset the input register holds a=0, sel=0, str=1 (disabled),
//     so out=0 and _out=1 during and just after reset.
//   Undefined (default): out/_out are purely combinational from the ports,
//     and q/_q lag by one cycle.
// ---------------------------------------------------------------------------
module sn74xx151 #(
  parameter logic RESET_Q = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [2:0] sel,
  input  logic       str,
  output logic       out,
  output logic       _out,
  output logic       q,
  output logic       _q
);

  // Selector operands: either the raw ports or their registered copies.
  logic [7:0] a_s;
  logic [2:0] sel_s;
  logic       str_s;

`ifdef SN74XX151_INPUT_REG_EN
  logic [7:0] a_r;
  logic [2:0] sel_r;
  logic       str_r;

  // The strobe resets to 1 so the selector is disabled while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= 8'h00;
      sel_r <= 3'd0;
      str_r <= 1'b1;
    end else begin
      a_r   <= a;
      sel_r <= sel;
      str_r <= str;
    end
  end

  assign a_s   = a_r;
  assign sel_s = sel_r;
  assign str_s = str_r;
`else
  assign a_s   = a;
  assign sel_s = sel;
  assign str_s = str;
`endif

  // The strobe is ANDed in rather than used in a mux.
  // With str=1 the result is a hard 0 even when sel is X/Z.
  always_comb begin
    out  = ~str_s & a_s[sel_s];
    _out = ~out;
  end

  // Output register stage. Reset acts asynchronously, without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q  <= RESET_Q;
      _q <= ~RESET_Q;
    end else begin
      q  <= out;
      _q <= _out;
    end
  end

endmodule

// File: tb/tb_sn74xx151.sv
// ---------------------------------------------------------------------------
// tb_sn74xx151 -- self-checking bench for sn74xx151.
//
// The reference model is a behavioural statement of the function:
// Y = 0 when the strobe is high, otherwise bit sel of a. Expected registered
// values flow through exp_q and are popped one clock edge later. The bench
// also follows SN74XX151_INPUT_REG_EN when that macro is defined.
// ---------------------------------------------------------------------------
module tb_sn74xx151;

  localparam logic RQ = 1'b0;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a;
  logic [2:0] sel;
  logic       str;
  logic       out, _out, q, _q;

  always #5 clk = ~clk;

  sn74xx151 #(.RESET_Q(RQ)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .sel (sel),
    .str (str),
    .out (out),
    ._out(_out),
    .q   (q),
    ._q  (_q)
  );

  // ---------------- reference model ----------------
  logic       exp_q[$];      // expected registered Y, one entry per edge
  logic       m_q;           // model of the registered Y
  logic [7:0] m_a;           // model input register (input-register build only)
  logic [2:0] m_sel;
  logic       m_str;

  function automatic logic y_of(input logic [7:0] av, input logic [2:0] sv,
                                input logic st);
    if (st) return 1'b0;
    return ((av >> sv) & 8'd1) != 8'd0;
  endfunction

  function automatic logic model_out();
`ifdef SN74XX151_INPUT_REG_EN
    return y_of(m_a, m_sel, m_str);
`else
    return y_of(a, sel, str);
`endif
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_comb(input string tag);
    logic e;
    e = model_out();
    check({tag, ".out"},  {31'd0, out},  {31'd0, e});
    check({tag, "._out"}, {31'd0, _out}, {31'd0, ~e});
  endtask

  task automatic check_reg(input string tag);
    check({tag, ".q"},  {31'd0, q},  {31'd0, m_q});
    check({tag, "._q"}, {31'd0, _q}, {31'd0, ~m_q});
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input logic [7:0] av, input logic [2:0] sv,
                       input logic st);
    a = av; sel = sv; str = st;
    #1;
  endtask

  // One clock edge. The model captures what is settled just before the edge.
  task automatic tick();
    logic y_pre;
    y_pre = model_out();
    if (rst) exp_q.push_back(RQ);
    else     exp_q.push_back(y_pre);
    @(posedge clk);
    if (!rst) begin
`ifdef SN74XX151_INPUT_REG_EN
      m_a = a; m_sel = sel; m_str = str;
`endif
    end
    m_q = exp_q.pop_front();
    #1;
  endtask

  task automatic assert_reset();
    rst = 1'b1;
    m_q = RQ;
    m_a = 8'h00; m_sel = 3'd0; m_str = 1'b1;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    a = 8'h00; sel = 3'd0; str = 1'b1;
    m_a = 8'h00; m_sel = 3'd0; m_str = 1'b1; m_q = RQ;
    assert_reset();
    check_reg("reset");
    check_comb("reset");
    tick(); tick();
    check_reg("reset_held");
    #2 rst = 1'b0;
    #1;
    check_reg("reset_release");

    // a=A5, strobe enabled, step all select codes
    for (int i = 0; i < 8; i++) begin
      apply(8'hA5, 3'(i), 1'b0);
`ifdef SN74XX151_INPUT_REG_EN
      tick();
`endif
      check_comb($sformatf("a5_en_sel%0d", i));
    end

    // a=A5, strobe disabled: out=0 for every select code
    for (int i = 0; i < 8; i++) begin
      apply(8'hA5, 3'(i), 1'b1);
`ifdef SN74XX151_INPUT_REG_EN
      tick();
`endif
      check_comb($sformatf("a5_dis_sel%0d", i));
    end

    // a=5A, sel=3: Y is 1, and registered after the edge
    apply(8'h5A, 3'd3, 1'b0);
    check_comb("5a_sel3_pre");
    tick();
    check_comb("5a_sel3_post");
    check_reg("5a_sel3");
    tick();
    check_reg("5a_sel3_2");

    // Async reset mid-cycle while q=1, held across an edge, released
    #2;
    assert_reset();
    check_reg("mid_rst_immediate");
    check_comb("mid_rst_comb");
    tick();
    check_reg("mid_rst_held");
    #2 rst = 1'b0;
    #1;
    check_reg("mid_rst_released");
    tick();
    check_reg("mid_rst_first_capture");
    tick();
    check_reg("mid_rst_second_capture");

    // a and str change in the same timestep: the disabled result wins
    apply(8'h00, 3'd7, 1'b0);
    tick();
    apply(8'hFF, 3'd7, 1'b1);
    check_comb("simul_change");
    tick();
    check_reg("simul_change");
    check_comb("simul_change_post");

    // Input-register latency: a=01, sel=0, str=0 after reset
    assert_reset();
    tick();
    #2 rst = 1'b0;
    apply(8'h01, 3'd0, 1'b0);
    check_comb("lat_0");
    tick();
    check_comb("lat_1");
    check_reg("lat_1");
    tick();
    check_comb("lat_2");
    check_reg("lat_2");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      apply(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) == 0));
      check_comb("rand_pre");
      tick();
      check_comb("rand_post");
      check_reg("rand");
    end

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
